// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by Fetch and Memory stages.
// Memory stage wins ties; each access holds the port for MEM_LAT cycles.
module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MEM_LAT = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          InstrReqF,
   input  logic [AW-1:0] PCF,
   input  logic          FlushF,
   output logic [DW-1:0] InstrF,
   output logic          InstrValidF,
   output logic          StallFetch,
   input  logic          DataReqM,
   input  logic          MemWriteM,
   input  logic [AW-1:0] ALUOutM,
   input  logic [DW-1:0] WriteDataM,
   output logic [DW-1:0] ReadDataM,
   output logic          DataValidM,
   output logic          StallMem,
   output logic          MemEn,
   output logic [AW-1:0] MemAddr,
   output logic          MemWE,
   output logic [DW-1:0] MemWD,
   input  logic [DW-1:0] MemRD
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_D = 2'd1,
      BUSY_I = 2'd2
   } state_t;

   localparam logic [3:0] LatInit = 4'(MEM_LAT - 1);

   state_t        state;
   logic [3:0]    cnt;
   logic [AW-1:0] addrQ;
   logic [DW-1:0] dataQ;
   logic          writeQ;
   logic          cancel;
   logic          dreq;
   logic          ireq;
   logic          busy;

   // Masking by the valid pulse keeps a served request from re-granting.
   assign dreq = DataReqM & ~DataValidM;
   assign ireq = InstrReqF & ~InstrValidF;
   assign busy = (state != IDLE);

   assign StallMem   = dreq;
   assign StallFetch = ireq | dreq;

   assign MemEn   = busy;
   assign MemAddr = busy ? addrQ : '0;
   assign MemWD   = busy ? dataQ : '0;
   assign MemWE   = (state == BUSY_D) & writeQ & (cnt == 4'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         addrQ       <= '0;
         dataQ       <= '0;
         writeQ      <= 1'b0;
         cancel      <= 1'b0;
         InstrF      <= '0;
         ReadDataM   <= '0;
         InstrValidF <= 1'b0;
         DataValidM  <= 1'b0;
      end else begin
         InstrValidF <= 1'b0;
         DataValidM  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (dreq) begin
                  state  <= BUSY_D;
                  addrQ  <= ALUOutM;
                  dataQ  <= WriteDataM;
                  writeQ <= MemWriteM;
                  cnt    <= LatInit;
               end else if (ireq) begin
                  state  <= BUSY_I;
                  addrQ  <= PCF;
                  cnt    <= LatInit;
                  cancel <= 1'b0;
               end
            end
            BUSY_D: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  state      <= IDLE;
                  DataValidM <= 1'b1;
                  if (!writeQ) ReadDataM <= MemRD;
               end
            end
            BUSY_I: begin
               if (FlushF) cancel <= 1'b1;
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  state <= IDLE;
                  // A flush anywhere in the access discards the word.
                  if (!cancel && !FlushF) begin
                     InstrF      <= MemRD;
                     InstrValidF <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: instance A uses MEM_LAT=2, instance B uses MEM_LAT=3.
// Both share stimulus; each step checks the instance it targets.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        InstrReqF;
   logic [31:0] PCF;
   logic        FlushF;
   logic        DataReqM;
   logic        MemWriteM;
   logic [31:0] ALUOutM;
   logic [31:0] WriteDataM;
   logic [31:0] MemRD;

   logic [31:0] instrA, rdA, addrA, wdA;
   logic        ivA, dvA, sfA, smA, enA, weA;
   logic [31:0] instrB, rdB, addrB, wdB;
   logic        ivB, dvB, sfB, smB, enB, weB;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2)) dutA (
      .clk(clk), .reset(reset),
      .InstrReqF(InstrReqF), .PCF(PCF), .FlushF(FlushF),
      .InstrF(instrA), .InstrValidF(ivA), .StallFetch(sfA),
      .DataReqM(DataReqM), .MemWriteM(MemWriteM),
      .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
      .ReadDataM(rdA), .DataValidM(dvA), .StallMem(smA),
      .MemEn(enA), .MemAddr(addrA), .MemWE(weA), .MemWD(wdA),
      .MemRD(MemRD)
   );

   mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) dutB (
      .clk(clk), .reset(reset),
      .InstrReqF(InstrReqF), .PCF(PCF), .FlushF(FlushF),
      .InstrF(instrB), .InstrValidF(ivB), .StallFetch(sfB),
      .DataReqM(DataReqM), .MemWriteM(MemWriteM),
      .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
      .ReadDataM(rdB), .DataValidM(dvB), .StallMem(smB),
      .MemEn(enB), .MemAddr(addrB), .MemWE(weB), .MemWD(wdB),
      .MemRD(MemRD)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic doReset();
      reset = 1'b1;
      InstrReqF = 1'b0;
      DataReqM = 1'b0;
      FlushF = 1'b0;
      MemWriteM = 1'b0;
      step();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      InstrReqF = 1'b1;
      DataReqM = 1'b1;
      FlushF = 1'b0;
      MemWriteM = 1'b0;
      PCF = 32'h10;
      ALUOutM = 32'h44;
      WriteDataM = 32'h0;
      MemRD = 32'h0;

      // 1: reset with both requests held
      step();
      step();
      chk("rst_en", {31'b0, enA}, 32'd0);
      chk("rst_addr", addrA, 32'd0);
      chk("rst_we", {31'b0, weA}, 32'd0);
      chk("rst_wd", wdA, 32'd0);
      chk("rst_instr", instrA, 32'd0);
      chk("rst_rd", rdA, 32'd0);
      chk("rst_iv", {31'b0, ivA}, 32'd0);
      chk("rst_dv", {31'b0, dvA}, 32'd0);
      reset = 1'b0;
      step();
      chk("rst_grant_en", {31'b0, enA}, 32'd1);
      chk("rst_grant_addr", addrA, 32'h44);

      // 2: fetch only, LAT=2
      doReset();
      InstrReqF = 1'b1;
      PCF = 32'h10;
      MemRD = 32'hE3A01005;
      settle();
      chk("f_c0_stall", {31'b0, sfA}, 32'd1);
      chk("f_c0_en", {31'b0, enA}, 32'd0);
      step();
      chk("f_c1_en", {31'b0, enA}, 32'd1);
      chk("f_c1_addr", addrA, 32'h10);
      chk("f_c1_stall", {31'b0, sfA}, 32'd1);
      step();
      chk("f_c2_en", {31'b0, enA}, 32'd1);
      chk("f_c2_stall", {31'b0, sfA}, 32'd1);
      chk("f_c2_iv", {31'b0, ivA}, 32'd0);
      step();
      chk("f_c3_iv", {31'b0, ivA}, 32'd1);
      chk("f_c3_instr", instrA, 32'hE3A01005);
      chk("f_c3_stall", {31'b0, sfA}, 32'd0);
      chk("f_c3_en", {31'b0, enA}, 32'd0);
      InstrReqF = 1'b0;
      step();
      chk("f_c4_iv", {31'b0, ivA}, 32'd0);

      // 3: simultaneous load and fetch, LAT=2
      doReset();
      DataReqM = 1'b1;
      MemWriteM = 1'b0;
      ALUOutM = 32'h80;
      InstrReqF = 1'b1;
      PCF = 32'h20;
      MemRD = 32'h55;
      settle();
      chk("lf_c0_sm", {31'b0, smA}, 32'd1);
      chk("lf_c0_sf", {31'b0, sfA}, 32'd1);
      step();
      chk("lf_c1_addr", addrA, 32'h80);
      chk("lf_c1_sf", {31'b0, sfA}, 32'd1);
      step();
      chk("lf_c2_sf", {31'b0, sfA}, 32'd1);
      chk("lf_c2_dv", {31'b0, dvA}, 32'd0);
      step();
      chk("lf_c3_dv", {31'b0, dvA}, 32'd1);
      chk("lf_c3_rd", rdA, 32'h55);
      chk("lf_c3_sm", {31'b0, smA}, 32'd0);
      chk("lf_c3_sf", {31'b0, sfA}, 32'd1);
      step();
      DataReqM = 1'b0;
      MemRD = 32'h1234;
      settle();
      chk("lf_c4_addr", addrA, 32'h20);
      chk("lf_c4_dv", {31'b0, dvA}, 32'd0);
      step();
      chk("lf_c5_addr", addrA, 32'h20);
      chk("lf_c5_iv", {31'b0, ivA}, 32'd0);
      step();
      chk("lf_c6_iv", {31'b0, ivA}, 32'd1);
      chk("lf_c6_instr", instrA, 32'h1234);
      chk("lf_c6_rd", rdA, 32'h55);

      // 4: load then store, LAT=3
      doReset();
      DataReqM = 1'b1;
      MemWriteM = 1'b0;
      ALUOutM = 32'h30;
      MemRD = 32'h77;
      step();
      step();
      step();
      chk("ld_c3_dv", {31'b0, dvB}, 32'd0);
      step();
      chk("ld_c4_dv", {31'b0, dvB}, 32'd1);
      chk("ld_c4_rd", rdB, 32'h77);
      DataReqM = 1'b0;
      step();
      DataReqM = 1'b1;
      MemWriteM = 1'b1;
      ALUOutM = 32'h40;
      WriteDataM = 32'hDEADBEEF;
      MemRD = 32'h0BAD;
      settle();
      chk("st_c0_we", {31'b0, weB}, 32'd0);
      step();
      chk("st_c1_we", {31'b0, weB}, 32'd0);
      chk("st_c1_en", {31'b0, enB}, 32'd1);
      step();
      chk("st_c2_we", {31'b0, weB}, 32'd0);
      step();
      chk("st_c3_we", {31'b0, weB}, 32'd1);
      chk("st_c3_addr", addrB, 32'h40);
      chk("st_c3_wd", wdB, 32'hDEADBEEF);
      step();
      chk("st_c4_we", {31'b0, weB}, 32'd0);
      chk("st_c4_dv", {31'b0, dvB}, 32'd1);
      chk("st_c4_rd", rdB, 32'h77);
      DataReqM = 1'b0;
      MemWriteM = 1'b0;
      step();
      chk("st_c5_dv", {31'b0, dvB}, 32'd0);

      // 5: flush during fetch, LAT=2
      doReset();
      InstrReqF = 1'b1;
      PCF = 32'h10;
      MemRD = 32'hAAAA;
      step();
      FlushF = 1'b1;
      PCF = 32'h100;
      settle();
      chk("fl_c1_addr", addrA, 32'h10);
      step();
      FlushF = 1'b0;
      settle();
      chk("fl_c2_addr", addrA, 32'h10);
      step();
      chk("fl_c3_iv", {31'b0, ivA}, 32'd0);
      chk("fl_c3_en", {31'b0, enA}, 32'd0);
      chk("fl_c3_sf", {31'b0, sfA}, 32'd1);
      step();
      chk("fl_c4_addr", addrA, 32'h100);
      chk("fl_c4_iv", {31'b0, ivA}, 32'd0);
      MemRD = 32'hBBBB;
      step();
      chk("fl_c5_addr", addrA, 32'h100);
      step();
      chk("fl_c6_iv", {31'b0, ivA}, 32'd1);
      chk("fl_c6_instr", instrA, 32'hBBBB);
      InstrReqF = 1'b0;

      // 6: reset in cycle 2 of a LAT=3 store
      doReset();
      DataReqM = 1'b1;
      MemWriteM = 1'b1;
      ALUOutM = 32'h40;
      WriteDataM = 32'h1111;
      step();
      chk("ra_c1_we", {31'b0, weB}, 32'd0);
      chk("ra_c1_en", {31'b0, enB}, 32'd1);
      step();
      reset = 1'b1;
      DataReqM = 1'b0;
      MemWriteM = 1'b0;
      settle();
      chk("ra_c2_we", {31'b0, weB}, 32'd0);
      step();
      chk("ra_c3_we", {31'b0, weB}, 32'd0);
      chk("ra_c3_en", {31'b0, enB}, 32'd0);
      chk("ra_c3_addr", addrB, 32'd0);
      chk("ra_c3_wd", wdB, 32'd0);
      chk("ra_c3_dv", {31'b0, dvB}, 32'd0);
      chk("ra_c3_iv", {31'b0, ivB}, 32'd0);
      chk("ra_c3_rd", rdB, 32'd0);
      chk("ra_c3_instr", instrB, 32'd0);
      chk("ra_c3_sm", {31'b0, smB}, 32'd0);
      chk("ra_c3_sf", {31'b0, sfB}, 32'd0);
      reset = 1'b0;
      step();
      chk("ra_c4_we", {31'b0, weB}, 32'd0);
      chk("ra_c4_en", {31'b0, enB}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
